// File: rtl/tx_line_sched_pkg.sv
// Shared definitions for the RS-485 line scheduler: fx register map, line modes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_line_sched_pkg;

    // fx register offsets within this module's 1 KiB window
    localparam logic [9:0] REG_LINE_MODE = 10'h000;
    localparam logic [9:0] REG_STATUS    = 10'h001;
    localparam logic [9:0] REG_FRM_CNT   = 10'h002;
    localparam logic [9:0] REG_ERR_CLR   = 10'h003;

    // Which driver(s) a frame goes out on
    typedef enum logic [1:0] {
        LM_A    = 2'd0,
        LM_B    = 2'd1,
        LM_ALT  = 2'd2,
        LM_BOTH = 2'd3
    } line_mode_e;

    // Egress sequencing: DE lead guard, byte send/wait loop, DE tail guard
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_TAIL = 3'd4
    } state_e;

endpackage

// File: rtl/tx_line_sched_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read (dout valid whenever not empty).
// Latency: a pushed word is visible on dout_o the cycle after the push.
// Backpressure: push when full is ignored unless a pop happens in the same cycle.
module tx_line_sched_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 9
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tx_line_sched.sv
// Buffers packed frames and plays them byte-by-byte onto RS-485 line A/B with DE guard times.
// Latency: frame starts egress 1 cycle after its end is seen, then DE_LEAD_US us of DE lead.
// Backpressure: none upstream (overflowing bytes/frames are dropped and flagged); waits on tx_busy.
module tx_line_sched
    import tx_line_sched_pkg::*;
#(
    parameter int DAT_AW       = 9,
    parameter int LEN_DEPTH_AW = 2,
    parameter int DE_LEAD_US   = 2,
    parameter int DE_TAIL_US   = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic [7:0]  pk_data,
    input  logic        pk_vld,
    input  logic        pk_frm,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        sel_b,
    output logic        de_a,
    output logic        de_b,
    input  logic [15:0] fx_waddr,
    input  logic        fx_wr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [15:0] fx_raddr,
    output logic [7:0]  fx_q,
    input  logic [5:0]  mod_id
);
    localparam logic [7:0] LEAD_LAST = 8'(DE_LEAD_US - 1);
    localparam logic [7:0] TAIL_LAST = 8'(DE_TAIL_US - 1);

    state_e     state_q, state_d;
    line_mode_e line_mode_q;

    logic       pk_frm_q, acc_q;
    logic [9:0] byte_cnt_q;
    logic       frm_rise, frm_fall, acc_now, byte_in;

    logic       dat_push, dat_pop, dat_empty, dat_full;
    logic [7:0] dat_dout;
    logic       len_push, len_pop, len_empty, len_full;
    logic [9:0] len_dout;

    logic [9:0] rem_q;
    logic [7:0] us_q;
    logic       use_a_q, use_b_q, sel_b_q, alt_q, wait1_q;
    logic [7:0] frm_cnt_q;
    logic       err_lenovf_q, err_datovf_q;
    logic [7:0] fx_q_q, rd_mux;
    logic       lead_done, tail_done, wait_done, busy, de_any;
    logic       fx_wsel, err_clr, lenovf_set, datovf_set;

    // ---------------- ingress ----------------
    assign frm_rise = pk_frm & ~pk_frm_q;
    assign frm_fall = ~pk_frm & pk_frm_q;
    // Admission is decided on the first cycle of a frame, so bytes on that cycle count too
    assign acc_now  = frm_rise ? ~len_full : acc_q;
    assign byte_in  = pk_frm & pk_vld & acc_now;
    assign dat_push = byte_in & (~dat_full | dat_pop);
    assign len_push = frm_fall & acc_q & (byte_cnt_q != '0);

    assign lenovf_set = frm_rise & len_full;
    assign datovf_set = byte_in & ~dat_push;

    // Frame edge tracking, admission flag and per-frame count of stored bytes
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pk_frm_q   <= 1'b0;
            acc_q      <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            pk_frm_q <= pk_frm;
            if (frm_rise)      acc_q <= ~len_full;
            else if (frm_fall) acc_q <= 1'b0;
            if (frm_rise)      byte_cnt_q <= {9'd0, dat_push};
            else if (dat_push) byte_cnt_q <= byte_cnt_q + 10'd1;
        end
    end

    tx_line_sched_sync_fifo #(.W(8), .AW(DAT_AW)) u_dat_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push_i  (dat_push),
        .din_i   (pk_data),
        .pop_i   (dat_pop),
        .dout_o  (dat_dout),
        .empty_o (dat_empty),
        .full_o  (dat_full)
    );

    tx_line_sched_sync_fifo #(.W(10), .AW(LEN_DEPTH_AW)) u_len_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push_i  (len_push),
        .din_i   (byte_cnt_q),
        .pop_i   (len_pop),
        .dout_o  (len_dout),
        .empty_o (len_empty),
        .full_o  (len_full)
    );

    // ---------------- egress FSM ----------------
    assign lead_done = pluse_us & (us_q == LEAD_LAST);
    assign tail_done = pluse_us & (us_q == TAIL_LAST);
    // The cycle right after tx_start is skipped: the serializer may not have raised busy yet
    assign wait_done = ~wait1_q & ~tx_busy;

    // State register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!len_empty) state_d = ST_LEAD;
            ST_LEAD: if (lead_done)  state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: if (wait_done)  state_d = (rem_q != '0) ? ST_SEND : ST_TAIL;
            ST_TAIL: if (tail_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; DE follows the line choice latched at frame start
    always_comb begin
        len_pop  = 1'b0;
        dat_pop  = 1'b0;
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        de_a     = 1'b0;
        de_b     = 1'b0;
        case (state_q)
            ST_IDLE: len_pop = ~len_empty;
            ST_SEND: begin
                dat_pop  = ~dat_empty;
                tx_start = 1'b1;
                tx_byte  = dat_dout;
            end
            default: ;
        endcase
        if (state_q != ST_IDLE) begin
            de_a = use_a_q;
            de_b = use_b_q;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign de_any = de_a | de_b;
    assign sel_b  = sel_b_q & busy;

    // Egress datapath: remaining bytes, us guard counter, line selection, frame counter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            us_q      <= '0;
            use_a_q   <= 1'b0;
            use_b_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            alt_q     <= 1'b0;
            wait1_q   <= 1'b0;
            frm_cnt_q <= '0;
        end else begin
            wait1_q <= (state_q == ST_SEND);
            case (state_q)
                ST_IDLE: if (!len_empty) begin
                    rem_q <= len_dout;
                    us_q  <= '0;
                    case (line_mode_q)
                        LM_A:    begin use_a_q <= 1'b1;   use_b_q <= 1'b0;  sel_b_q <= 1'b0;  end
                        LM_B:    begin use_a_q <= 1'b0;   use_b_q <= 1'b1;  sel_b_q <= 1'b1;  end
                        LM_ALT:  begin use_a_q <= ~alt_q; use_b_q <= alt_q; sel_b_q <= alt_q; end
                        default: begin use_a_q <= 1'b1;   use_b_q <= 1'b1;  sel_b_q <= 1'b0;  end
                    endcase
                end
                ST_LEAD: if (pluse_us) us_q <= us_q + 8'd1;
                ST_SEND: rem_q <= rem_q - 10'd1;
                ST_WAIT: if (wait_done && rem_q == '0) us_q <= '0;
                ST_TAIL: if (pluse_us) begin
                    if (tail_done) begin
                        alt_q     <= ~alt_q;
                        frm_cnt_q <= frm_cnt_q + 8'd1;
                    end else begin
                        us_q <= us_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- fx bus ----------------
    assign fx_wsel = fx_wr & (fx_waddr[15:10] == mod_id);
    assign err_clr = fx_wsel & (fx_waddr[9:0] == REG_ERR_CLR) & fx_data[0];

    // Read mux; unmapped offsets and other module ids read as zero
    always_comb begin
        rd_mux = 8'h00;
        if (fx_raddr[15:10] == mod_id) begin
            case (fx_raddr[9:0])
                REG_LINE_MODE: rd_mux = {6'd0, line_mode_q};
                REG_STATUS:    rd_mux = {4'd0, err_lenovf_q, err_datovf_q, busy, de_any};
                REG_FRM_CNT:   rd_mux = frm_cnt_q;
                default:       rd_mux = 8'h00;
            endcase
        end
    end

    // Config/error registers and the held read-data register; error set beats clear
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            line_mode_q  <= LM_A;
            err_lenovf_q <= 1'b0;
            err_datovf_q <= 1'b0;
            fx_q_q       <= 8'h00;
        end else begin
            if (fx_wsel && fx_waddr[9:0] == REG_LINE_MODE) line_mode_q <= line_mode_e'(fx_data[1:0]);
            if (lenovf_set)   err_lenovf_q <= 1'b1;
            else if (err_clr) err_lenovf_q <= 1'b0;
            if (datovf_set)   err_datovf_q <= 1'b1;
            else if (err_clr) err_datovf_q <= 1'b0;
            if (fx_rd) fx_q_q <= rd_mux;
        end
    end

    assign fx_q = fx_q_q;

endmodule

// File: tb/tb_tx_line_sched.sv
// Directed bench for tx_line_sched with a busy-counter serializer model and DE timing monitor.
// Latency: n/a.
// Backpressure: serializer busy can be held high to stall egress.
module tb_tx_line_sched;
    localparam int BUSY_CYC = 4;
    localparam logic [15:0] BASE = 16'h1400;   // mod_id 5 in [15:10]

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        pluse_us = 1'b0;
    logic [7:0]  pk_data = 8'h00;
    logic        pk_vld = 1'b0;
    logic        pk_frm = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        sel_b, de_a, de_b;
    logic [15:0] fx_waddr = 16'h0;
    logic        fx_wr = 1'b0;
    logic [7:0]  fx_data = 8'h00;
    logic        fx_rd = 1'b0;
    logic [15:0] fx_raddr = 16'h0;
    logic [7:0]  fx_q;
    logic [5:0]  mod_id = 6'h05;

    int errors = 0;
    int checks = 0;

    // serializer model / monitor state
    bit         hold_busy = 1'b0;
    int         busy_cnt = 0;
    bit         started = 1'b0, low_seen = 1'b0, de_prev = 1'b0;
    int         lead_n = 0, tail_n = 0, de_cyc = 0, ab_both = 0;
    logic [7:0] rx_q[$];
    logic [2:0] ln_q[$];
    int         lead_q[$];
    int         tail_q[$];

    tx_line_sched dut (
        .clk_sys (clk_sys), .rst_n (rst_n), .pluse_us (pluse_us),
        .pk_data (pk_data), .pk_vld (pk_vld), .pk_frm (pk_frm),
        .tx_byte (tx_byte), .tx_start (tx_start), .tx_busy (tx_busy),
        .sel_b (sel_b), .de_a (de_a), .de_b (de_b),
        .fx_waddr (fx_waddr), .fx_wr (fx_wr), .fx_data (fx_data),
        .fx_rd (fx_rd), .fx_raddr (fx_raddr), .fx_q (fx_q), .mod_id (mod_id)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 1 us tick: one cycle high every 10 cycles
    initial begin
        forever begin
            repeat (9) @(posedge clk_sys);
            #1 pluse_us = 1'b1;
            @(posedge clk_sys);
            #1 pluse_us = 1'b0;
        end
    end

    // Serializer model and DE/guard monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk_sys);
            if (tx_start) begin
                rx_q.push_back(tx_byte);
                ln_q.push_back({de_a, de_b, sel_b});
                busy_cnt = BUSY_CYC;
                started  = 1'b1;
                low_seen = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = hold_busy || (busy_cnt != 0);
            if (de_a && de_b) ab_both++;
            if (de_a || de_b) begin
                de_cyc++;
                if (!started && pluse_us) lead_n++;
                if (started && !tx_start && !tx_busy) begin
                    if (low_seen && pluse_us) tail_n++;
                    low_seen = 1'b1;
                end
            end else if (de_prev) begin
                lead_q.push_back(lead_n);
                tail_q.push_back(tail_n);
                lead_n = 0; tail_n = 0; started = 1'b0; low_seen = 1'b0;
            end
            de_prev = de_a || de_b;
        end
    end

    task automatic clear_mon();
        rx_q.delete(); ln_q.delete(); lead_q.delete(); tail_q.delete();
        lead_n = 0; tail_n = 0; de_cyc = 0; ab_both = 0;
        started = 1'b0; low_seen = 1'b0; busy_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_sys); #1;
        rst_n = 1'b0; hold_busy = 1'b0; pk_frm = 1'b0; pk_vld = 1'b0;
        repeat (2) @(posedge clk_sys); #1;
        clear_mon();
        rst_n = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic fx_write(input logic [9:0] r, input logic [7:0] d);
        fx_waddr = {mod_id, r}; fx_data = d; fx_wr = 1'b1;
        @(posedge clk_sys); #1 fx_wr = 1'b0;
    endtask

    task automatic fx_read(input logic [15:0] a, output logic [7:0] d);
        fx_raddr = a; fx_rd = 1'b1;
        @(posedge clk_sys); #1 fx_rd = 1'b0;
        d = fx_q;
    endtask

    task automatic send_frame(input int len, input int base);
        @(posedge clk_sys); #1 pk_frm = 1'b1;
        for (int i = 0; i < len; i++) begin
            pk_vld = 1'b1; pk_data = 8'(base + i);
            @(posedge clk_sys); #1;
        end
        pk_vld = 1'b0;
        if (len == 0) begin repeat (3) @(posedge clk_sys); #1; end
        pk_frm = 1'b0;
        repeat (2) @(posedge clk_sys); #1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int c = 0;
        while (tail_q.size() < n && c < budget) begin
            @(posedge clk_sys); #1; c++;
        end
        chk(tag, tail_q.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int c;

        // ---- reset state ----
        #12;
        chk("rst_de_a", de_a, 0);
        chk("rst_de_b", de_b, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_fx_q", fx_q, 0);
        @(posedge clk_sys); #1 rst_n = 1'b1;
        @(posedge clk_sys); #1;
        fx_read(BASE + 16'h001, d); chk("rst_status", d, 8'h00);
        fx_read(BASE + 16'h000, d); chk("rst_line_mode", d, 8'h00);

        // ---- T1: line A, 5-byte frame ----
        fx_write(10'h000, 8'h00);
        send_frame(5, 8'h11);
        wait_frames(1, 2000, "t1_done");
        chk("t1_nbytes", rx_q.size(), 5);
        for (int i = 0; i < rx_q.size(); i++) begin
            chk("t1_byte", rx_q[i], 8'h11 + i);
            chk("t1_line", ln_q[i], 3'b100);
        end
        chk("t1_lead_us", lead_q[0], 2);
        chk("t1_tail_us", tail_q[0], 2);
        fx_read(BASE + 16'h002, d); chk("t1_frm_cnt", d, 1);
        repeat (3) @(posedge clk_sys); #1;
        chk("t1_fx_q_hold", fx_q, 1);
        fx_read(16'h0002, d); chk("t1_other_id", d, 0);
        fx_read(BASE + 16'h001, d); chk("t1_status", d, 8'h00);

        // ---- T2: alternate mode, three frames A/B/A ----
        do_reset();
        fx_write(10'h000, 8'h02);
        send_frame(3, 8'h00);
        send_frame(3, 8'h10);
        send_frame(3, 8'h20);
        wait_frames(3, 3000, "t2_done");
        chk("t2_nbytes", rx_q.size(), 9);
        for (int i = 0; i < rx_q.size(); i++) begin
            chk("t2_byte", rx_q[i], (i / 3) * 16 + (i % 3));
            chk("t2_line", ln_q[i], ((i / 3) == 1) ? 3'b011 : 3'b100);
        end
        chk("t2_ab_overlap", ab_both, 0);
        chk("t2_tail_us", tail_q[1], 2);
        fx_read(BASE + 16'h002, d); chk("t2_frm_cnt", d, 3);

        // ---- T2b: both lines ----
        do_reset();
        fx_write(10'h000, 8'h03);
        send_frame(2, 8'h50);
        wait_frames(1, 2000, "t2b_done");
        chk("t2b_line", ln_q[0], 3'b110);

        // ---- T3: length FIFO overflow while serializer stalled ----
        do_reset();
        hold_busy = 1'b1;
        send_frame(2, 8'h00);                 // occupies the FSM, stuck in WAIT
        for (int f = 1; f <= 6; f++) send_frame(2, f * 16);
        fx_read(BASE + 16'h001, d); chk("t3_status_ovf", d, 8'h0B);
        fx_write(10'h003, 8'h01);
        fx_read(BASE + 16'h001, d); chk("t3_status_clr", d, 8'h03);
        hold_busy = 1'b0;
        wait_frames(5, 4000, "t3_done");
        chk("t3_nbytes", rx_q.size(), 10);
        if (rx_q.size() == 10) begin
            chk("t3_byte2", rx_q[2], 8'h10);
            chk("t3_last", rx_q[9], 8'h41);
        end
        repeat (200) @(posedge clk_sys); #1;
        chk("t3_no_extra", tail_q.size(), 5);
        fx_read(BASE + 16'h002, d); chk("t3_frm_cnt", d, 5);

        // ---- T4: data FIFO overflow, 600-byte frame ----
        do_reset();
        send_frame(600, 0);
        wait_frames(1, 8000, "t4_done");
        chk("t4_nbytes", rx_q.size(), 512);
        if (rx_q.size() == 512) begin
            chk("t4_first", rx_q[0], 8'h00);
            chk("t4_mid", rx_q[300], 8'h2C);
            chk("t4_last", rx_q[511], 8'hFF);
        end
        fx_read(BASE + 16'h001, d); chk("t4_status", d, 8'h04);

        // ---- T5: empty frame ----
        do_reset();
        send_frame(0, 0);
        repeat (100) @(posedge clk_sys); #1;
        chk("t5_de_cycles", de_cyc, 0);
        chk("t5_frames", tail_q.size(), 0);
        fx_read(BASE + 16'h002, d); chk("t5_frm_cnt", d, 0);

        // ---- T6: reset during WAIT ----
        do_reset();
        hold_busy = 1'b1;
        send_frame(3, 8'h60);
        c = 0;
        while (rx_q.size() < 1 && c < 1000) begin @(posedge clk_sys); #1; c++; end
        repeat (3) @(posedge clk_sys); #1;
        chk("t6_de_a_before", de_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_de_a_rst", de_a, 0);
        chk("t6_de_b_rst", de_b, 0);
        chk("t6_start_rst", tx_start, 0);
        @(posedge clk_sys); #1;
        hold_busy = 1'b0;
        clear_mon();
        rst_n = 1'b1;
        fx_read(BASE + 16'h001, d); chk("t6_status", d, 8'h00);
        repeat (300) @(posedge clk_sys); #1;
        chk("t6_no_tx", rx_q.size(), 0);
        chk("t6_no_de", de_cyc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_line_sched.md
Name: tx_line_sched

Overview:
Schedules packed frames from the pack stage onto the two RS-485 output lines (A/B) of the slave FPGA.
- Buffers frame bytes in a data FIFO and records frame lengths in a length FIFO.
- Selects a line per frame, drives DE with lead and tail guard times measured in microsecond pulses, and feeds bytes one at a time to a byte serializer.
- Configuration and status are accessed over the fx bus.
- Sits between pack_top and the UART/line drivers inside the communication top.

Parameters:
DAT_AW, 9, data FIFO address width (512 bytes).
LEN_DEPTH_AW, 2, length FIFO address width (4 frames).
DE_LEAD_US, 2, pluse_us count from DE assert to the first tx_start.
DE_TAIL_US, 2, pluse_us count from the last byte done to DE deassert.

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pluse_us  in  1  one-cycle pulse every 1 us
pk_data  in  8  packed byte
pk_vld  in  1  pk_data valid (only while pk_frm=1)
pk_frm  in  1  high for the duration of a frame
tx_byte  out  8  byte to the serializer
tx_start  out  1  one-cycle start strobe to the serializer
tx_busy  in  1  serializer busy (rises the cycle after tx_start at the latest)
sel_b  out  1  0 = serializer routed to line A, 1 = line B
de_a  out  1  line A driver enable
de_b  out  1  line B driver enable
fx_waddr  in  16  fx write address; [15:10] = module id, [9:0] = register
fx_wr  in  1  fx write strobe
fx_data  in  8  fx write data
fx_rd  in  1  fx read strobe
fx_raddr  in  16  fx read address
fx_q  out  8  fx read data; 0 when not addressed
mod_id  in  6  this module's fx id

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0; FIFOs empty; state IDLE; registers cleared. Asserting reset mid-frame aborts the transfer immediately (DE low that cycle).
- Ingress:
  - Rising edge of pk_frm: if the length FIFO is full, the whole frame is dropped and err_lenovf is set. Otherwise the byte counter is cleared and the frame is accepted.
  - Each pk_vld in an accepted frame writes pk_data to the data FIFO and increments the counter.
  - If the data FIFO is full, the byte is dropped and err_datovf is set.
  - Falling edge of pk_frm pushes the counter (10 bits) to the length FIFO if the counter is >0. Zero-length frames are discarded.
- Line choice is latched in IDLE at frame start from line_mode:
  - 0 = A only
  - 1 = B only
  - 2 = alternate, starting with A after reset and toggling after each completed frame
  - 3 = both: de_a and de_b are asserted together, sel_b = 0
- FSM:
  - IDLE -> LEAD when the length FIFO is non-empty: pop the length into rem_cnt, assert de_x, clear the us counter.
  - LEAD -> SEND after DE_LEAD_US pluse_us pulses.
  - SEND: pop the data FIFO, drive tx_byte, pulse tx_start for 1 cycle, decrement rem_cnt -> WAIT.
  - WAIT: wait for tx_busy to go low (ignore the first cycle after tx_start). Go to SEND if rem_cnt != 0, else to TAIL and clear the us counter.
  - TAIL -> IDLE after DE_TAIL_US pulses: deassert DE, toggle the alternate pointer, increment frm_cnt (8-bit, wraps 255 -> 0).
- Ingress and egress may happen in the same cycle, including a push and a pop on the same FIFO in one cycle; the FIFO count stays unchanged in that case.
- fx bus: addressed when addr[15:10] == mod_id.
  - Registers:
    - 0x000 line_mode[1:0], RW
    - 0x001 status, RO: {4'b0, err_lenovf, err_datovf, busy, de_any}
    - 0x002 frm_cnt, RO
    - 0x003 error clear: writing 1 to bit0 clears the err bits
  - A write to line_mode takes effect at the next frame start.
  - fx_q is registered: valid 1 cycle after fx_rd, held until the next fx_rd, and 0 when not addressed.
  - An error set and an error clear in the same cycle: set wins.

Decomposition:
- Shared package holds the register offsets (0x000–0x003), the line_mode encodings, and the FSM state encoding.
- Sub-module sync_fifo (parameterised width and address width) is instantiated twice: data 8-bit wide, length 10-bit wide.

Test Plan:
1. line_mode=0; one 5-byte frame -> de_a high; the first tx_start comes 2 pluse_us later; 5 tx_start with the bytes in order; de_a low 2 us after the last busy falls; frm_cnt=1.
2. line_mode=2; three 3-byte frames back-to-back -> served on lines A, B, A; de_b never high during an A frame; frm_cnt=3.
3. Six frames sent while the serializer is held busy -> the fifth and sixth frames are dropped; err_lenovf=1; status reads 0x08|busy bits; after write 0x003=1 the error bits read 0.
4. A 600-byte frame -> 512 bytes are transmitted; err_datovf=1; the length entry equals 512.
5. pk_frm pulse with no pk_vld -> no DE activity; frm_cnt unchanged.
6. Reset asserted during WAIT -> de_a/de_b/tx_start are 0 immediately; after release, state is IDLE, FIFOs are empty, and fx read of 0x001 returns 0.
